led_ctrl: RTL and testbench
===========================

// Module: led_ctrl
// PURPOSE
//  Memory-mapped LED controller that drives NUM_LEDS LED outputs from the CPU MMIO bus.
//  It offers three modes: direct, per-channel PWM brightness, and a hardware one-hot chaser.
//  The chaser lets the LED walk pattern run without software polling.
//  It sits behind the CPU's MMIO decoder and drives the top-level leds pins.
// PARAMETERS
//  NUM_LEDS  4   LED channel count, 1..16
//  PWM_W     8   PWM counter width; PWM period = 2**PWM_W clk cycles
//  PRESC_W   16  prescaler width; sets the chase tick rate
//  ADDR_W    8   byte-address width of the register window
// PORTS
//  clk    in   1         system clock; all logic is on the rising edge
//  rst_n  in   1         asynchronous active-low reset
//  wr_en  in   1         write strobe, sampled at clk rising edge
//  rd_en  in   1         read strobe, sampled at clk rising edge
//  addr   in   ADDR_W    byte address, word aligned; addr[1:0] is ignored
//  wdata  in   32        write data
//  rdata  out  32        read data, registered
//  leds   out  NUM_LEDS  LED drive, registered
// BEHAVIOUR
//  Registers (all reset to 0):
//   0x00 CTRL[2:0]      bits [1:0] mode (0 direct, 1 PWM, 2 chase, 3 reserved = all LEDs off); bit [2] en
//   0x04 DATA           [NUM_LEDS-1:0] direct-mode pattern
//   0x08 PRESC          [PRESC_W-1:0]; one tick every PRESC+1 clk cycles
//   0x0C CPER           [15:0]; chase advances one step every CPER+1 ticks
//   0x10 STAT           read-only; [3:0] current chase index
//   0x20+4*i DUTY[i]    [PWM_W:0] for i < NUM_LEDS; LED i is on while pwm_cnt < DUTY[i]
//                       DUTY = 0 is always off; DUTY >= 2**PWM_W is always on
//  Bus:
//   - Write lands at the edge where wr_en=1.
//   - rdata is valid the cycle after rd_en=1 and holds until the next read.
//   - Unmapped or out-of-range DUTY reads return 0. Writes there and to STAT are ignored.
//   - wr_en and rd_en together: the write is performed, and the read returns the old value.
//  Output update:
//   - leds is registered. A config write at edge E is visible on leds after edge E+1.
//   - en=0 forces leds=0. Counters keep running in that state, except the chase counters are held.
//  Direct mode: leds <= DATA[NUM_LEDS-1:0].
//  PWM mode:
//   - pwm_cnt is free-running on clk, PWM_W bits, wrapping 2**PWM_W-1 -> 0.
//   - pwm_cnt is independent of the prescaler.
//  Chase mode:
//   - State is CH_IDLE or CH_RUN.
//   - CH_IDLE -> CH_RUN when mode==2 && en. On that entry: chase index=0 (leds=1), tick count=0, step count=0.
//   - CH_RUN -> CH_IDLE when mode!=2 or en=0.
//   - In CH_RUN, each time the step count reaches CPER on a tick, the index increments. NUM_LEDS-1 wraps to 0.
//   - leds = 1 << index.
//  Prescaler:
//   - Counts 0..PRESC and emits a 1-cycle tick at PRESC. PRESC=0 gives a tick every cycle.
//   - A write to PRESC or CTRL clears the prescaler and step counters. That write wins over a tick in the same cycle.
//  Reset: rst_n low immediately clears leds, rdata, all registers, all counters and the FSM, including mid-operation.
//   Reset release is expected to be synchronised externally.
// TESTING
//  1. Hold rst_n=0, then release -> leds=0, and a read of every register returns 0.
//  2. Write CTRL=0x4, then DATA=0xA -> leds=4'b1010 after the next edge; STAT read returns 0.
//  3. PRESC=1, CPER=2, CTRL=0x6 -> leds 0001, 0010, 0100, 1000, 0001, with each step lasting exactly 6 cycles.
//  4. CTRL=0x5, DUTY0=64, DUTY1=0, DUTY2=256, DUTY3=128 -> per 256-cycle period, led0 is high 64 cycles,
//     led1 is never high, led2 is always high, and led3 is high 128 cycles.
//  5. Mid-chase (leds=0100), write CTRL=0x2 -> leds=0 after the next edge. Then write CTRL=0x6 -> leds restarts at 0001.
//  6. Pulse rst_n low asynchronously (between edges) mid-chase -> leds=0 with no clock edge.
//     After release, the chase stays off until CTRL is rewritten.

Source files
------------

// File: rtl/led_ctrl.sv
// Memory-mapped LED controller: direct pattern, per-channel PWM brightness and
// a hardware one-hot chaser, all driving registered LED outputs.
module led_ctrl #(
  parameter int NUM_LEDS = 4,
  parameter int PWM_W    = 8,
  parameter int PRESC_W  = 16,
  parameter int ADDR_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic [NUM_LEDS-1:0] leds
);

  localparam int WA_W = ADDR_W - 2;

  localparam logic [WA_W-1:0] A_CTRL  = WA_W'(0);
  localparam logic [WA_W-1:0] A_DATA  = WA_W'(1);
  localparam logic [WA_W-1:0] A_PRESC = WA_W'(2);
  localparam logic [WA_W-1:0] A_CPER  = WA_W'(3);
  localparam logic [WA_W-1:0] A_STAT  = WA_W'(4);

  localparam logic [1:0] MODE_DIRECT = 2'd0;
  localparam logic [1:0] MODE_PWM    = 2'd1;
  localparam logic [1:0] MODE_CHASE  = 2'd2;

  typedef enum logic {
    CH_IDLE,
    CH_RUN
  } chase_state_t;

  logic [WA_W-1:0]     word_addr;
  logic [2:0]          ctrl;
  logic [NUM_LEDS-1:0] data;
  logic [PRESC_W-1:0]  presc;
  logic [15:0]         cper;
  logic [PWM_W:0]      duty [NUM_LEDS];

  logic [PWM_W-1:0]    pwm_cnt;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [15:0]         step_q, step_d;
  logic [3:0]          index_q, index_d;
  chase_state_t        state_q, state_d;

  logic                en;
  logic [1:0]          mode;
  logic                chase_on;
  logic                tick;
  logic                cfg_clr;
  logic [NUM_LEDS-1:0] pwm_leds;
  logic [NUM_LEDS-1:0] leds_d;
  logic [31:0]         rd_val;
  logic                unused_bits;

  assign word_addr   = addr[ADDR_W-1:2];
  assign en          = ctrl[2];
  assign mode        = ctrl[1:0];
  assign chase_on    = en && (mode == MODE_CHASE);
  assign tick        = (presc_q == presc);
  assign cfg_clr     = wr_en && ((word_addr == A_CTRL) || (word_addr == A_PRESC));
  assign unused_bits = ^{wdata, addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl  <= '0;
      data  <= '0;
      presc <= '0;
      cper  <= '0;
      for (int i = 0; i < NUM_LEDS; i++) duty[i] <= '0;
    end else if (wr_en) begin
      case (word_addr)
        A_CTRL:  ctrl  <= wdata[2:0];
        A_DATA:  data  <= wdata[NUM_LEDS-1:0];
        A_PRESC: presc <= wdata[PRESC_W-1:0];
        A_CPER:  cper  <= wdata[15:0];
        default: ;
      endcase
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (word_addr == WA_W'(8 + i)) duty[i] <= wdata[PWM_W:0];
      end
    end
  end

  // Read mux sees pre-write register values, so a simultaneous read returns the old value.
  always_comb begin
    rd_val = '0;
    case (word_addr)
      A_CTRL:  rd_val = {29'b0, ctrl};
      A_DATA:  rd_val = 32'(data);
      A_PRESC: rd_val = 32'(presc);
      A_CPER:  rd_val = 32'(cper);
      A_STAT:  rd_val = {28'b0, index_q};
      default: ;
    endcase
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (word_addr == WA_W'(8 + i)) rd_val = 32'(duty[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= rd_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_IDLE;
      presc_q <= '0;
      step_q  <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      step_q  <= step_d;
      index_q <= index_d;
    end
  end

  // A CTRL/PRESC write clears the counters and swallows any tick in that cycle.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    index_d = index_q;
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    case (state_q)
      CH_IDLE: begin
        if (chase_on) begin
          state_d = CH_RUN;
          index_d = '0;
          step_d  = '0;
          presc_d = '0;
        end
      end
      CH_RUN: begin
        if (!chase_on) begin
          state_d = CH_IDLE;
        end else if (tick && !cfg_clr) begin
          if (step_q == cper) begin
            step_d  = '0;
            index_d = (index_q == 4'(NUM_LEDS - 1)) ? 4'd0 : index_q + 4'd1;
          end else begin
            step_d = step_q + 16'd1;
          end
        end
      end
      default: state_d = CH_IDLE;
    endcase
    if (cfg_clr) begin
      presc_d = '0;
      step_d  = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      pwm_leds[i] = ({1'b0, pwm_cnt} < duty[i]);
    end
  end

  // Chase output uses the next index so the first step shows 1 on the entry edge.
  always_comb begin
    leds_d = '0;
    if (en) begin
      case (mode)
        MODE_DIRECT: leds_d = data;
        MODE_PWM:    leds_d = pwm_leds;
        MODE_CHASE:  leds_d = NUM_LEDS'(1) << index_d;
        default:     leds_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds <= '0;
    end else begin
      leds <= leds_d;
    end
  end

endmodule

// File: tb/tb_led_ctrl.sv
// Self-checking bench for led_ctrl: random register traffic, chase timing and
// PWM duty checked against a register-level model kept in the bench.
module tb_led_ctrl;

  localparam int NUM_LEDS = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [NUM_LEDS-1:0] leds;

  int check_count = 0;
  int error_count = 0;

  logic [31:0] m_ctrl, m_data, m_presc, m_cper;
  logic [31:0] m_duty [NUM_LEDS];

  led_ctrl #(.NUM_LEDS(NUM_LEDS), .PWM_W(8), .PRESC_W(16), .ADDR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .leds  (leds)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One bus cycle: drive after a falling edge, DUT samples on the following rising edge.
  task automatic applyStimulus(input logic do_wr, input logic do_rd, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = do_wr;
    rd_en = do_rd;
    addr  = a;
    wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic model_reset();
    m_ctrl = 0; m_data = 0; m_presc = 0; m_cper = 0;
    for (int i = 0; i < NUM_LEDS; i++) m_duty[i] = 0;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [31:0] d);
    case (a)
      8'h00: m_ctrl  = d & 32'h7;
      8'h04: m_data  = d & 32'hF;
      8'h08: m_presc = d & 32'hFFFF;
      8'h0C: m_cper  = d & 32'hFFFF;
      default: begin
        for (int i = 0; i < NUM_LEDS; i++)
          if (a == 8'(32 + 4 * i)) m_duty[i] = d & 32'h1FF;
      end
    endcase
  endtask

  function automatic logic [31:0] exp_read(input logic [7:0] a);
    logic [31:0] v;
    v = 0;
    case (a)
      8'h00: v = m_ctrl;
      8'h04: v = m_data;
      8'h08: v = m_presc;
      8'h0C: v = m_cper;
      default: begin
        for (int i = 0; i < NUM_LEDS; i++)
          if (a == 8'(32 + 4 * i)) v = m_duty[i];
      end
    endcase
    return v;
  endfunction

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, a, d);
    model_write(a, d);
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d);
    applyStimulus(1'b0, 1'b1, a, 32'h0);
    d = rdata;
  endtask

  // Chase model: leds walk one position every step_len cycles after the enabling edge.
  function automatic logic [31:0] chase_led(input int k, input int step_len);
    return 32'(1) << ((k / step_len) % NUM_LEDS);
  endfunction

  task automatic start_chase(input int p, input int c);
    do_write(8'h00, 32'h0);
    do_write(8'h08, 32'(p));
    do_write(8'h0C, 32'(c));
    do_write(8'h00, 32'h6);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rv, v, old_v;
    logic [7:0]  a;
    logic [7:0]  rd_list [12];
    logic [7:0]  rw_list [7];
    int          step_len, p, c;
    int          on_cnt [NUM_LEDS];
    logic [31:0] duty_set [NUM_LEDS];

    rd_list = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20, 8'h24, 8'h28, 8'h2C, 8'h14, 8'h30, 8'hFC};
    rw_list = '{8'h04, 8'h08, 8'h0C, 8'h20, 8'h24, 8'h28, 8'h2C};
    model_reset();

    // Reset state and all-zero register file
    repeat (3) @(negedge clk);
    checkOutput("rst_leds", 32'(leds), 32'h0);
    rst_n = 1'b1;
    foreach (rd_list[i]) begin
      do_read(rd_list[i], rv);
      checkOutput($sformatf("rst_rd_%0h", rd_list[i]), rv, 32'h0);
    end

    // Direct mode
    do_write(8'h00, 32'h4);
    do_write(8'h04, 32'hA);
    @(negedge clk);
    checkOutput("direct_a", 32'(leds), 32'hA);
    do_read(8'h10, rv);
    checkOutput("direct_stat", rv, 32'h0);
    for (int n = 0; n < 8; n++) begin
      v = $urandom;
      do_write(8'h04, v);
      @(negedge clk);
      checkOutput("direct_rand", 32'(leds), v & 32'hF);
    end
    do_write(8'h00, 32'h0);
    @(negedge clk);
    checkOutput("direct_en_off", 32'(leds), 32'h0);
    do_write(8'h00, 32'h7);
    @(negedge clk);
    checkOutput("mode3_off", 32'(leds), 32'h0);
    do_write(8'h00, 32'h4);

    // Random register read-back, ignored writes, unmapped reads
    for (int n = 0; n < 12; n++) begin
      a = rw_list[$urandom_range(0, 6)];
      v = $urandom;
      do_write(a, v);
      do_read(a, rv);
      checkOutput($sformatf("rdback_%0h", a), rv, exp_read(a));
    end
    applyStimulus(1'b1, 1'b0, 8'h10, 32'hF);
    applyStimulus(1'b1, 1'b0, 8'h30, 32'hFF);
    do_read(8'h10, rv);
    checkOutput("stat_wr_ignored", rv, 32'h0);
    do_read(8'h30, rv);
    checkOutput("duty_oob_rd", rv, 32'h0);
    do_read(8'h03, rv);
    checkOutput("addr_lsb_ignored", rv, exp_read(8'h00));

    // Simultaneous write and read returns the old value, then rdata holds
    old_v = 32'h5;
    do_write(8'h04, old_v);
    v = 32'h3;
    applyStimulus(1'b1, 1'b1, 8'h04, v);
    checkOutput("rw_same_old", rdata, old_v);
    model_write(8'h04, v);
    do_read(8'h04, rv);
    checkOutput("rw_same_new", rv, 32'h3);
    repeat (5) @(negedge clk);
    checkOutput("rdata_hold", rdata, 32'h3);

    // Chase: fixed case then random prescaler/period
    for (int r = 0; r < 4; r++) begin
      p = (r == 0) ? 1 : $urandom_range(0, 2);
      c = (r == 0) ? 2 : $urandom_range(1, 3);
      step_len = (p + 1) * (c + 1);
      start_chase(p, c);
      for (int k = 0; k <= 4 * step_len; k++) begin
        checkOutput($sformatf("chase_p%0d_c%0d_k%0d", p, c, k), 32'(leds), chase_led(k, step_len));
        if (k < 4 * step_len) @(negedge clk);
      end
    end

    // Stop mid-chase at 0100, then restart from 0001
    start_chase(1, 2);
    step_len = 6;
    for (int k = 0; k < 2 * step_len; k++) @(negedge clk);
    checkOutput("stop_pre", 32'(leds), 32'h4);
    do_write(8'h00, 32'h2);
    @(negedge clk);
    checkOutput("stop_leds", 32'(leds), 32'h0);
    repeat (10) @(negedge clk);
    do_read(8'h10, rv);
    checkOutput("stop_stat_held", rv, 32'h2);
    do_write(8'h00, 32'h6);
    @(negedge clk);
    for (int k = 0; k <= step_len; k++) begin
      checkOutput($sformatf("restart_k%0d", k), 32'(leds), chase_led(k, step_len));
      if (k < step_len) @(negedge clk);
    end

    // PWM: on-time per 256-cycle period equals min(duty, 256)
    for (int r = 0; r < 4; r++) begin
      if (r == 0) duty_set = '{32'd64, 32'd0, 32'd256, 32'd128};
      else if (r == 1) duty_set = '{32'd1, 32'd255, 32'd257, 32'd511};
      else foreach (duty_set[i]) duty_set[i] = 32'($urandom_range(0, 300));
      do_write(8'h00, 32'h5);
      foreach (duty_set[i]) do_write(8'(32 + 4 * i), duty_set[i]);
      repeat (2) @(negedge clk);
      foreach (on_cnt[i]) on_cnt[i] = 0;
      for (int t = 0; t < 256; t++) begin
        @(negedge clk);
        for (int i = 0; i < NUM_LEDS; i++) on_cnt[i] += int'(leds[i]);
      end
      for (int i = 0; i < NUM_LEDS; i++)
        checkOutput($sformatf("pwm_r%0d_led%0d", r, i), 32'(on_cnt[i]),
                    32'((m_duty[i] > 256) ? 256 : m_duty[i]));
    end
    do_write(8'h00, 32'h1);
    @(negedge clk);
    checkOutput("pwm_en_off", 32'(leds), 32'h0);

    // Asynchronous reset between edges mid-chase
    do_write(8'h04, 32'hA);
    do_read(8'h04, rv);
    start_chase(0, 1);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_leds", 32'(leds), 32'h0);
    checkOutput("async_rst_rdata", rdata, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("post_rst_leds", 32'(leds), 32'h0);
    foreach (rd_list[i]) begin
      if (i < 5) begin
        do_read(rd_list[i], rv);
        checkOutput($sformatf("post_rst_rd_%0h", rd_list[i]), rv, 32'h0);
      end
    end
    do_write(8'h00, 32'h6);
    @(negedge clk);
    checkOutput("post_rst_rechase", 32'(leds), 32'h1);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
